// File: rtl/fifo_operand_reader.sv
// rtl/fifo_operand_reader.sv - pairs FIFO words into (A, B) MAC operands with group-last flag
// Optional pair_count output under READER_PAIR_CNT_EN.
module fifo_operand_reader #(
    parameter int DATA_W    = 16,
    parameter int GROUP_LEN = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_last,
    output logic              busy
`ifdef READER_PAIR_CNT_EN
    ,
    output logic [15:0]       pair_count
`endif
);

    localparam int CW = (GROUP_LEN > 2) ? $clog2(GROUP_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(GROUP_LEN - 1);

    typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, PRESENT} state_t;

    state_t        state;
    logic [CW-1:0] grp_cnt;
    logic          fetching;

    assign fetching = (state == FETCH_A) || (state == FETCH_B);
    // Flush masks the pop so a word arriving during the abort stays in the FIFO.
    assign fifo_ren = fetching && !fifo_empty && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grp_cnt   <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            grp_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= FETCH_A;
                        busy  <= 1'b1;
                    end
                end
                FETCH_A: begin
                    if (fifo_ren) begin
                        out_a <= fifo_rdata;
                        state <= FETCH_B;
                    end
                end
                FETCH_B: begin
                    if (fifo_ren) begin
                        out_b     <= fifo_rdata;
                        state     <= PRESENT;
                        out_valid <= 1'b1;
                        out_last  <= (grp_cnt == LAST_IDX);
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        grp_cnt   <= (grp_cnt == LAST_IDX) ? '0 : grp_cnt + 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (enable) begin
                            state <= FETCH_A;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef READER_PAIR_CNT_EN
    // Lifetime delivery count; survives flush, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pair_count <= 16'd0;
        end else if (!flush && state == PRESENT && out_ready) begin
            pair_count <= pair_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_operand_reader.sv
// tb/tb_fifo_operand_reader.sv - directed vector bench for fifo_operand_reader
module tb_fifo_operand_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [15:0] fifo_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        out_last;
    logic        busy;
`ifdef READER_PAIR_CNT_EN
    logic [15:0] pair_count;
`endif

    fifo_operand_reader #(.DATA_W(16), .GROUP_LEN(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_rdata (fifo_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_last   (out_last),
        .busy       (busy)
`ifdef READER_PAIR_CNT_EN
        ,
        .pair_count (pair_count)
`endif
    );

    always #5 clock = ~clock;

    // FIFO model: show-ahead read data, pointer advances on the fifo_ren edge.
    logic [15:0] mem [0:127];
    int wptr = 0;
    int rptr = 0;
    assign fifo_empty = (rptr == wptr);
    assign fifo_rdata = mem[rptr[6:0]];

    always @(posedge clock) begin
        if (fifo_ren) rptr <= rptr + 1;
    end

    logic [15:0] hs_a [$];
    logic [15:0] hs_b [$];
    logic        hs_l [$];
    int ren_cnt = 0;
    int valid_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (fifo_ren) ren_cnt++;
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready && !flush) begin
                hs_a.push_back(out_a);
                hs_b.push_back(out_b);
                hs_l.push_back(out_last);
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wptr[6:0]] = w;
        wptr++;
    endtask

    task automatic wait_hs(input int n, input int bound);
        int c = 0;
        while (hs_a.size() < n && c < bound) begin
            tick();
            c++;
        end
        check("hs_reached", 32'(hs_a.size() >= n), 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
    } vec_t;

    vec_t grp_tbl [8];

    initial begin
        int base_hs, base_ren, base_val, c;

        grp_tbl[0] = '{16'h1000, 16'h1001, 1'b0};
        grp_tbl[1] = '{16'h1002, 16'h1003, 1'b0};
        grp_tbl[2] = '{16'h1004, 16'h1005, 1'b0};
        grp_tbl[3] = '{16'h1006, 16'h1007, 1'b0};
        grp_tbl[4] = '{16'h1008, 16'h1009, 1'b0};
        grp_tbl[5] = '{16'h100A, 16'h100B, 1'b0};
        grp_tbl[6] = '{16'h100C, 16'h100D, 1'b0};
        grp_tbl[7] = '{16'h100E, 16'h100F, 1'b1};

        reset = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_ren", fifo_ren, 0);
        check("rst_busy", busy, 0);
        check("rst_a", out_a, 0);
        check("rst_b", out_b, 0);
`ifdef READER_PAIR_CNT_EN
        check("rst_pc", pair_count, 0);
`endif
        tick(); tick();
        reset = 1'b1;

        // Basic pair
        base_ren = ren_cnt; base_val = valid_cnt; base_hs = hs_a.size();
        push(16'h3C00); push(16'h4000);
        enable = 1'b1; out_ready = 1'b1;
        wait_hs(base_hs + 1, 20);
        tick(); tick();
        check("basic_a", hs_a[base_hs], 16'h3C00);
        check("basic_b", hs_b[base_hs], 16'h4000);
        check("basic_last", hs_l[base_hs], 0);
        check("basic_ren_cycles", ren_cnt - base_ren, 2);
        check("basic_valid_cycles", valid_cnt - base_val, 1);
        pulse_flush();
        check("flush_idle_busy", busy, 0);

        // Group boundary, table driven
        base_hs = hs_a.size();
        for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i));
        wait_hs(base_hs + 8, 100);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("grp_a[%0d]", k), hs_a[base_hs + k], grp_tbl[k].a);
            check($sformatf("grp_b[%0d]", k), hs_b[base_hs + k], grp_tbl[k].b);
            check($sformatf("grp_last[%0d]", k), hs_l[base_hs + k], grp_tbl[k].last);
        end
        check("grp_busy", busy, 1);
        push(16'h0101); push(16'h0202);
        wait_hs(base_hs + 9, 20);
        check("grp_wrap_last", hs_l[base_hs + 8], 0);
        pulse_flush();

        // Underflow stall in FETCH_B
        base_ren = ren_cnt; base_val = valid_cnt; base_hs = hs_a.size();
        push(16'h5555);
        repeat (6) tick();
        check("uf_ren_cycles", ren_cnt - base_ren, 1);
        check("uf_no_valid", valid_cnt - base_val, 0);
        check("uf_busy", busy, 1);
        check("uf_ren_now", fifo_ren, 0);
        push(16'hC000);
        wait_hs(base_hs + 1, 20);
        check("uf_a", hs_a[base_hs], 16'h5555);
        check("uf_b", hs_b[base_hs], 16'hC000);

        // Backpressure with words still waiting in the FIFO
        out_ready = 1'b0;
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        c = 0;
        while (!out_valid && c < 20) begin tick(); c++; end
        check("bp_valid_seen", out_valid, 1);
        base_hs = hs_a.size();
        repeat (5) begin
            tick();
            check("bp_a_stable", out_a, 16'h1111);
            check("bp_b_stable", out_b, 16'h2222);
            check("bp_last_stable", out_last, 0);
            check("bp_no_ren", fifo_ren, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_one_hs", hs_a.size() - base_hs, 1);
        check("bp_valid_drop", out_valid, 0);
        enable = 1'b0;
        wait_hs(base_hs + 2, 20);
        tick();
        check("bp_second_b", hs_b[base_hs + 1], 16'h4444);
        check("bp_idle", busy, 0);

        // Flush while waiting in FETCH_B; group position was 3
        enable = 1'b1;
        base_ren = ren_cnt;
        push(16'hAAAA);
        c = 0;
        while (ren_cnt - base_ren < 1 && c < 20) begin tick(); c++; end
        check("fl_popped_a", ren_cnt - base_ren, 1);
        push(16'hBBBB);
        flush = 1'b1;
        #1;
        check("fl_ren_masked", fifo_ren, 0);
        tick();
        flush = 1'b0;
        check("fl_busy", busy, 0);
        check("fl_valid", out_valid, 0);
        base_hs = hs_a.size();
        push(16'hCCCC);
        for (int i = 0; i < 14; i++) push(16'h2000 + 16'(i));
        wait_hs(base_hs + 8, 100);
        check("fl_fresh_a", hs_a[base_hs], 16'hBBBB);
        check("fl_fresh_b", hs_b[base_hs], 16'hCCCC);
        for (int k = 0; k < 8; k++)
            check($sformatf("fl_last[%0d]", k), hs_l[base_hs + k], 32'(k == 7));

        // Asynchronous reset mid-fetch
        push(16'hDDDD);
        repeat (3) tick();
        check("ar_busy_before", busy, 1);
        #3;
        reset = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_last", out_last, 0);
        check("ar_ren", fifo_ren, 0);
        check("ar_busy", busy, 0);
        check("ar_a", out_a, 0);
        check("ar_b", out_b, 0);
`ifdef READER_PAIR_CNT_EN
        check("ar_pc", pair_count, 0);
`endif
        tick();
        reset = 1'b1;
        base_hs = hs_a.size();
        push(16'h7777); push(16'h8888);
        wait_hs(base_hs + 1, 20);
        check("ar_fresh_a", hs_a[base_hs], 16'h7777);
        check("ar_fresh_b", hs_b[base_hs], 16'h8888);

`ifdef READER_PAIR_CNT_EN
        push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
        wait_hs(base_hs + 3, 40);
        check("pc_three", pair_count, 3);
        pulse_flush();
        tick();
        check("pc_after_flush", pair_count, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/fifo_operand_reader.md
# fifo_operand_reader

Read-side controller for the 16-entry operand FIFO that feeds the pipelined FPMAC. It pops 16-bit half-precision words from the FIFO two at a time, forming an (A, B) operand pair. It presents each pair to the MAC input stage over a valid/ready handshake and flags the last pair of each accumulation group so the MAC knows when to close and emit its sum.

## Interface
Parameters:
- DATA_W, 16, operand width; must match FIFO word width.
- GROUP_LEN, 8, pairs per accumulation group; legal range 1..256.

Ports (reset asynchronous, active-low, named reset; clock named clock):
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  level; permits starting a new pair fetch.
- flush  input  1  synchronous abort; discards partial pair and group position.
- fifo_empty  input  1  FIFO empty flag.
- fifo_ren  output  1  FIFO read enable (combinational).
- fifo_rdata  input  DATA_W  FIFO read data; valid in the same cycle fifo_ren is high.
- out_valid  output  1  operand pair valid.
- out_ready  input  1  MAC accepts pair.
- out_a  output  DATA_W  operand A (first word popped).
- out_b  output  DATA_W  operand B (second word popped).
- out_last  output  1  pair is final of its group.
- busy  output  1  high in any state other than IDLE.
- pair_count  output  16  total pairs delivered (only with READER_PAIR_CNT_EN).

## Operation
- FSM states: IDLE, FETCH_A, FETCH_B, PRESENT.
- IDLE: when enable=1, go to FETCH_A.
- FETCH_A: fifo_ren = !fifo_empty. When fifo_ren=1, capture fifo_rdata into A and go to FETCH_B. Otherwise stay in FETCH_A.
- FETCH_B: same rule as FETCH_A, capturing into B. On capture, go to PRESENT.
- PRESENT: out_valid=1. out_a, out_b and out_last hold stable until the handshake (out_valid & out_ready). On handshake:
  - the group counter advances;
  - go to FETCH_A if enable=1, else IDLE.
- fifo_ren is never high outside FETCH_A/FETCH_B, and never high while fifo_empty=1.
- Group counter: width max(1, clog2(GROUP_LEN)).
  - Increments on each handshake and wraps from GROUP_LEN-1 to 0.
  - out_last = out_valid & (counter == GROUP_LEN-1).
  - With GROUP_LEN=1, out_last is high on every pair.
- enable is sampled only in IDLE and at the PRESENT handshake. Deasserting enable mid-fetch does not abort the fetch.
- flush has priority over all other events:
  - next state is IDLE and the group counter clears;
  - A/B are not cleared and out_valid drops the next cycle;
  - fifo_ren is forced 0 in the flush cycle, so no word is lost mid-flush;
  - a word already popped into A is discarded.
- Reset (asynchronous) values: state IDLE; A, B, out_a, out_b all 0; out_valid 0; out_last 0; fifo_ren 0; busy 0; group counter 0; pair_count 0.
  - Reset mid-fetch discards any captured word.
- busy = (state != IDLE).

## Timing
- fifo_ren is combinational from state, fifo_empty and flush; the FIFO pointer advances at the same edge at which A/B capture.
- With a non-empty FIFO: pop A at edge n, pop B at edge n+1; out_valid is high after edge n+1.
- Maximum throughput: one pair per 3 cycles with out_ready held high (FETCH_A, FETCH_B, PRESENT).
- An empty FIFO stalls FETCH_A/FETCH_B indefinitely with no partial output.
- out_ready low stalls PRESENT; no FIFO reads occur while presenting.
- All outputs other than fifo_ren are registered or decoded from registered state.

## Configuration
- READER_PAIR_CNT_EN defined: pair_count port exists.
  - 16-bit count of handshakes; wraps at 65535 to 0.
  - Cleared by reset only; flush does not clear it.
- READER_PAIR_CNT_EN undefined: pair_count port and its register are absent. All other behaviour is identical.

## Test plan
- Basic pair: FIFO holds 0x3C00, 0x4000; enable=1, out_ready=1.
  - Required: fifo_ren high for exactly 2 cycles.
  - out_a=0x3C00, out_b=0x4000, out_valid for 1 cycle, out_last=0 (GROUP_LEN=8).
- Group boundary: 16 words pushed, GROUP_LEN=8, out_ready=1.
  - Required: 8 pairs delivered; out_last high only on pair 8.
  - Group counter back to 0; busy stays high while enable=1.
- Underflow stall: FIFO holds 1 word.
  - Required: A captured, FSM waits in FETCH_B with fifo_ren=0 and no out_valid.
  - Pushing a 2nd word (0xC000) then yields a pair with out_b=0xC000.
- Backpressure: out_ready=0 for 5 cycles during PRESENT.
  - Required: out_a/out_b/out_last are stable and fifo_ren=0 throughout.
  - Exactly one handshake occurs when out_ready rises.
- Flush/reset mid-operation:
  - flush pulse in FETCH_B → IDLE next cycle, no out_valid, group counter 0, the next pair starts from a fresh word.
  - reset pulse asserted mid-clock → all outputs 0 immediately.
- Macro: build with READER_PAIR_CNT_EN; deliver 3 pairs, then flush.
  - Required: pair_count=3 before and after the flush; pair_count=0 after reset.
